// File: rtl/sonar_hcsr04_interface.sv
// HC-SR04 sonar front end: trigger pulse, echo width to distance in cm as 3-digit BCD.
// Optional watchdog/timeout path is enabled by defining SONAR_TIMEOUT_EN.
module sonar_hcsr04_interface #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned TRIGGER_CLKS = 500,
    parameter int unsigned TICKS_PER_CM = 2941,
    parameter int unsigned TIMEOUT_CLKS = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int unsigned TickW = $clog2(TICKS_PER_CM);
    localparam int unsigned TrigW = $clog2(TRIGGER_CLKS + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_CM - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(TICKS_PER_CM / 2);
    localparam logic [TrigW-1:0] TrigLast = TrigW'(TRIGGER_CLKS - 1);

    typedef enum logic [3:0] {
        Inicial      = 4'd0,
        Prepara      = 4'd1,
        EnviaTrigger = 4'd2,
        EsperaEcho   = 4'd3,
        Medindo      = 4'd4,
        Arredonda    = 4'd5,
        Armazena     = 4'd6,
        Final        = 4'd7,
        Erro         = 4'd8
    } state_e;

    state_e state_q, state_d;

    logic             echo_s1, echo_s2, echo_prev;
    logic             echo_rise, echo_fall;
    logic [TrigW-1:0] trig_q, trig_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [11:0]      medida_q, medida_d;
    logic             timeout;

    // Saturating BCD increment: 999 holds.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        if (v == 12'h999) begin
            return v;
        end else if (v[3:0] != 4'd9) begin
            return {v[11:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd9) begin
            return {v[11:8], v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[11:8] + 4'd1, 8'h00};
        end
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            echo_s1   <= 1'b0;
            echo_s2   <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_s1   <= echo;
            echo_s2   <= echo_s1;
            echo_prev <= echo_s2;
        end
    end

    assign echo_rise = echo_s2 & ~echo_prev;
    assign echo_fall = ~echo_s2 & echo_prev;

`ifdef SONAR_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CLKS - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           waiting;
    logic           erro_q, erro_d;

    assign waiting = (state_q == EsperaEcho) || (state_q == Medindo);
    assign timeout = waiting && (wd_q == WdLast);

    always_comb begin
        wd_d = wd_q;
        if (state_q == Prepara) begin
            wd_d = '0;
        end else if (waiting) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Result flag lands together with medida so it is valid while pronto is high.
    always_comb begin
        erro_d = erro_q;
        if (state_q == Armazena) begin
            erro_d = 1'b0;
        end else if (state_d == Erro) begin
            erro_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q   <= '0;
            erro_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            erro_q <= erro_d;
        end
    end

    assign erro = erro_q;
`else
    assign timeout = 1'b0;
    assign erro    = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= Inicial;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a falling edge beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Inicial:      if (medir) state_d = Prepara;
            Prepara:      state_d = EnviaTrigger;
            EnviaTrigger: if (trig_q == TrigLast) state_d = EsperaEcho;
            EsperaEcho: begin
                if (echo_rise) state_d = Medindo;
                else if (timeout) state_d = Erro;
            end
            Medindo: begin
                if (echo_fall) state_d = Arredonda;
                else if (timeout) state_d = Erro;
            end
            Arredonda:    state_d = Armazena;
            Armazena:     state_d = Final;
            Final:        state_d = Inicial;
            Erro:         state_d = Inicial;
            default:      state_d = Inicial;
        endcase
    end

    // Outputs
    always_comb begin
        trigger   = (state_q == EnviaTrigger);
        pronto    = (state_q == Final) || (state_q == Erro);
        db_estado = state_q;
        medida    = medida_q;
    end

    // Datapath next-state
    always_comb begin
        trig_d   = trig_q;
        tick_d   = tick_q;
        bcd_d    = bcd_q;
        medida_d = medida_q;
        case (state_q)
            Prepara: begin
                trig_d = '0;
                tick_d = '0;
                bcd_d  = '0;
            end
            EnviaTrigger: trig_d = trig_q + 1'b1;
            Medindo: begin
                if (echo_s2) begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        bcd_d  = bcd_inc(bcd_q);
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            Arredonda: if (tick_q >= TickHalf) bcd_d = bcd_inc(bcd_q);
            Armazena:  medida_d = bcd_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_q   <= '0;
            tick_q   <= '0;
            bcd_q    <= '0;
            medida_q <= '0;
        end else begin
            trig_q   <= trig_d;
            tick_q   <= tick_d;
            bcd_q    <= bcd_d;
            medida_q <= medida_d;
        end
    end

endmodule
